// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter (CPU + TRNG DMA) onto one memory slave port.
// Optional slave-wait timeout compiled in with `define MEM_BUS_ARBITER_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no owner; slave port quiet, arbitrate pending requests
//   GNT0  | m0 (CPU) owns the slave port until s_ready, valid drop or timeout
//   GNT1  | m1 (DMA) owns the slave port until s_ready, valid drop or timeout
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic [1:0]  grant,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  logic   last_owner;
  logic   gnt0;
  logic   gnt1;
  logic   sel_valid;
  logic   timeout;
  logic   done;

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  assign gnt0 = (state == GNT0) && !rst;
  assign gnt1 = (state == GNT1) && !rst;

  always_comb begin
    sel_valid = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    if (gnt0) begin
      sel_valid = m0_valid;
      s_addr    = m0_addr;
      s_wdata   = m0_wdata;
      s_wstrb   = m0_wstrb;
    end else if (gnt1) begin
      sel_valid = m1_valid;
      s_addr    = m1_addr;
      s_wdata   = m1_wdata;
      s_wstrb   = m1_wstrb;
    end
  end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        bus_err_q;
  logic [31:0] err_addr_q;

  // Fires on the TIMEOUT_CYCLES-th stalled owner cycle; a late s_ready still wins.
  assign timeout = sel_valid && !s_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (state == IDLE)
        wait_cnt <= '0;
      else if (!s_ready)
        wait_cnt <= wait_cnt + 16'd1;
      if (timeout) begin
        bus_err_q <= 1'b1;
        if (!bus_err_q)
          err_addr_q <= s_addr;
      end
    end
  end

  assign bus_err  = bus_err_q && !rst;
  assign err_addr = rst ? '0 : err_addr_q;
`else
  assign timeout  = 1'b0;
  assign bus_err  = 1'b0;
  assign err_addr = '0;
`endif

  assign done     = sel_valid && (s_ready || timeout);
  assign s_valid  = sel_valid && !timeout;
  assign m0_ready = gnt0 && done;
  assign m1_ready = gnt1 && done;
  assign m0_rdata = m0_ready ? (timeout ? ERR_RDATA : s_rdata) : '0;
  assign m1_rdata = m1_ready ? (timeout ? ERR_RDATA : s_rdata) : '0;
  assign grant    = {gnt1, gnt0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid && m1_valid)
            state <= last_owner ? GNT0 : GNT1;
          else if (m0_valid)
            state <= GNT0;
          else if (m1_valid)
            state <= GNT1;
        end
        GNT0: begin
          if (!m0_valid) begin
            state <= IDLE;
          end else if (done) begin
            state      <= IDLE;
            last_owner <= 1'b0;
          end
        end
        GNT1: begin
          if (!m1_valid) begin
            state <= IDLE;
          end else if (done) begin
            state      <= IDLE;
            last_owner <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter; expected completions are queued at stimulus
// time and retired by a monitor on every ready pulse.
module tb_mem_bus_arbiter;

  localparam int unsigned TO_CYC  = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [1:0]  grant;
  logic        bus_err;
  logic [31:0] err_addr;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .ERR_RDATA(ERR_VAL)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .bus_err(bus_err), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [31:0] rd);
    exp_t e;
    e.id    = id;
    e.rdata = rd;
    sb_q.push_back(e);
  endtask

  // Every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (m0_ready || m1_ready) begin
      chk("both_ready", {31'b0, m0_ready & m1_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", {30'b0, m1_ready, m0_ready}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_owner", {31'b0, m1_ready}, {31'b0, e.id});
        chk("sb_rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
      end
    end
    if (!m0_ready) chk("m0_rdata_quiet", m0_rdata, 32'd0);
    if (!m1_ready) chk("m1_rdata_quiet", m1_rdata, 32'd0);
  end

  task automatic drop_all();
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    s_ready  = 1'b0;
  endtask

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  task automatic to_run(input logic who, input logic [31:0] addr, input logic ready_at_limit,
                        input logic [31:0] rd);
    if (who) begin m1_valid = 1'b1; m1_addr = addr; end
    else     begin m0_valid = 1'b1; m0_addr = addr; end
    s_ready = 1'b0;
    s_rdata = rd;
    push(who, ready_at_limit ? rd : ERR_VAL);
    @(negedge clk);
    chk("to_idle_grant", {30'b0, grant}, 32'd0);
    tick();
    for (int k = 1; k < int'(TO_CYC); k++) begin
      @(negedge clk);
      chk("to_wait_svalid", {31'b0, s_valid}, 32'd1);
      chk("to_wait_ready", {31'b0, m0_ready | m1_ready}, 32'd0);
      tick();
    end
    if (ready_at_limit) s_ready = 1'b1;
    @(negedge clk);
    chk("to_limit_svalid", {31'b0, s_valid}, {31'b0, ready_at_limit});
    chk("to_limit_ready", {31'b0, who ? m1_ready : m0_ready}, 32'd1);
    tick();
    drop_all();
  endtask
`endif

  initial begin
    logic [1:0] pat [8];
    pat = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    rst = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_rdata = '0; s_ready = 1'b0;
    tick();

    // Reset held with live requests and a ready slave: everything must stay quiet.
    m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = 32'h10; s_ready = 1'b1; s_rdata = 32'hFFFF;
    @(negedge clk);
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_svalid", {31'b0, s_valid}, 32'd0);
    chk("rst_saddr", s_addr, 32'd0);
    chk("rst_ready", {30'b0, m1_ready, m0_ready}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    tick();

    // Single m0 read, zero-wait slave.
    rst = 1'b0; m1_valid = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    push(1'b0, 32'h1234_5678);
    @(negedge clk);
    chk("rd_n_svalid", {31'b0, s_valid}, 32'd0);
    chk("rd_n_ready", {31'b0, m0_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("rd_n1_svalid", {31'b0, s_valid}, 32'd1);
    chk("rd_n1_saddr", s_addr, 32'h100);
    chk("rd_n1_grant", {30'b0, grant}, 32'd1);
    chk("rd_n1_ready", {31'b0, m0_ready}, 32'd1);
    tick();
    drop_all();
    @(negedge clk);
    chk("rd_after_grant", {30'b0, grant}, 32'd0);
    chk("rd_drain", sb_q.size(), 32'd0);

    // Continuous tie from reset: grants alternate with an IDLE cycle between.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h10; m1_valid = 1'b1; m1_addr = 32'h20;
    s_ready = 1'b1; s_rdata = 32'h1111;
    push(1'b0, 32'h1111); push(1'b1, 32'h1111); push(1'b0, 32'h1111); push(1'b1, 32'h1111);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", {30'b0, grant}, {30'b0, pat[k]});
      if (pat[k] == 2'b01) chk("rr_saddr0", s_addr, 32'h10);
      if (pat[k] == 2'b10) chk("rr_saddr1", s_addr, 32'h20);
      tick();
    end
    drop_all();
    @(negedge clk);
    chk("rr_drain", sb_q.size(), 32'd0);
    tick();

    // m1 write with 3 wait cycles; m0 arrives mid-transfer and must wait.
    m1_valid = 1'b1; m1_addr = 32'h300; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF;
    s_ready = 1'b0; s_rdata = 32'h1;
    push(1'b1, 32'h1);
    @(negedge clk);
    chk("wr_idle_grant", {30'b0, grant}, 32'd0);
    tick();
    for (int k = 1; k < 4; k++) begin
      if (k == 2) begin
        m0_valid = 1'b1; m0_addr = 32'h400; m0_wdata = '0; m0_wstrb = '0;
        push(1'b0, 32'h2);
      end
      @(negedge clk);
      chk("wr_wait_svalid", {31'b0, s_valid}, 32'd1);
      chk("wr_wait_wdata", s_wdata, 32'hCAFE_F00D);
      chk("wr_wait_wstrb", {28'b0, s_wstrb}, 32'hF);
      chk("wr_wait_ready", {30'b0, m1_ready, m0_ready}, 32'd0);
      tick();
    end
    s_ready = 1'b1;
    @(negedge clk);
    chk("wr_done_wdata", s_wdata, 32'hCAFE_F00D);
    chk("wr_done_m1_ready", {31'b0, m1_ready}, 32'd1);
    chk("wr_done_m0_ready", {31'b0, m0_ready}, 32'd0);
    tick();
    m1_valid = 1'b0; s_rdata = 32'h2;
    @(negedge clk);
    chk("wr_gap_grant", {30'b0, grant}, 32'd0);
    tick();
    @(negedge clk);
    chk("wr_m0_grant", {30'b0, grant}, 32'd1);
    chk("wr_m0_ready", {31'b0, m0_ready}, 32'd1);
    tick();
    drop_all();
    @(negedge clk);
    chk("wr_drain", sb_q.size(), 32'd0);
    tick();

    // Reset during a stalled GNT1 aborts it; the following tie goes to m0.
    m1_valid = 1'b1; m1_addr = 32'h500; s_ready = 1'b0;
    @(negedge clk);
    chk("ab_idle", {30'b0, grant}, 32'd0);
    tick();
    @(negedge clk);
    chk("ab_gnt1_a", {30'b0, grant}, 32'd2);
    tick();
    @(negedge clk);
    chk("ab_gnt1_b", {30'b0, grant}, 32'd2);
    tick();
    rst = 1'b1; s_ready = 1'b1;
    @(negedge clk);
    chk("ab_rst_ready", {31'b0, m1_ready}, 32'd0);
    chk("ab_rst_grant", {30'b0, grant}, 32'd0);
    tick();
    rst = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    chk("ab_post_grant", {30'b0, grant}, 32'd0);
    chk("ab_post_svalid", {31'b0, s_valid}, 32'd0);
    tick();
    m0_valid = 1'b1; m0_addr = 32'h600; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'h3;
    push(1'b0, 32'h3);
    @(negedge clk);
    chk("ab_tie_idle", {30'b0, grant}, 32'd0);
    tick();
    @(negedge clk);
    chk("ab_tie_m0", {30'b0, grant}, 32'd1);
    tick();
    drop_all();
    @(negedge clk);
    chk("ab_drain", sb_q.size(), 32'd0);
    tick();

    // m1 drops valid before s_ready: no ready, and last_owner (m0) is kept.
    m1_valid = 1'b1; m1_addr = 32'h700; s_ready = 1'b0;
    @(negedge clk);
    chk("pv_idle", {30'b0, grant}, 32'd0);
    tick();
    @(negedge clk);
    chk("pv_gnt1", {30'b0, grant}, 32'd2);
    tick();
    m1_valid = 1'b0; s_ready = 1'b1;
    @(negedge clk);
    chk("pv_no_ready", {31'b0, m1_ready}, 32'd0);
    chk("pv_svalid", {31'b0, s_valid}, 32'd0);
    tick();
    m0_valid = 1'b1; m1_valid = 1'b1; s_rdata = 32'h4;
    push(1'b1, 32'h4);
    @(negedge clk);
    chk("pv_back_idle", {30'b0, grant}, 32'd0);
    tick();
    @(negedge clk);
    chk("pv_tie_m1", {30'b0, grant}, 32'd2);
    tick();
    drop_all();
    @(negedge clk);
    chk("pv_drain", sb_q.size(), 32'd0);
    tick();

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    to_run(1'b0, 32'h4000, 1'b1, 32'h77);
    @(negedge clk);
    chk("to_late_ready_no_err", {31'b0, bus_err}, 32'd0);
    tick();
    to_run(1'b0, 32'h2000, 1'b0, 32'h0);
    @(negedge clk);
    chk("to_bus_err", {31'b0, bus_err}, 32'd1);
    chk("to_err_addr", err_addr, 32'h2000);
    tick();
    to_run(1'b1, 32'h3000, 1'b0, 32'h0);
    @(negedge clk);
    chk("to2_bus_err", {31'b0, bus_err}, 32'd1);
    chk("to2_err_addr_kept", err_addr, 32'h2000);
    chk("to_drain", sb_q.size(), 32'd0);
    tick();
`else
    // Without the timeout a long stall simply waits for the slave.
    m0_valid = 1'b1; m0_addr = 32'h800; s_ready = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    @(negedge clk);
    chk("st_wait_ready", {31'b0, m0_ready}, 32'd0);
    chk("st_wait_svalid", {31'b0, s_valid}, 32'd1);
    tick();
    s_ready = 1'b1; s_rdata = 32'h5;
    push(1'b0, 32'h5);
    @(negedge clk);
    chk("st_done_ready", {31'b0, m0_ready}, 32'd1);
    tick();
    drop_all();
    @(negedge clk);
    chk("st_bus_err", {31'b0, bus_err}, 32'd0);
    chk("st_err_addr", err_addr, 32'd0);
    chk("st_drain", sb_q.size(), 32'd0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
